// File: rtl/qa_drv_hc_pkg.sv
// Shared types and constants for the host-channel read driver.
package qa_drv_hc_pkg;

   typedef enum logic [1:0] {
      FAVOR_READER = 2'd0,
      FAVOR_WRITER = 2'd1,
      DRAIN        = 2'd2
   } t_RD_ARB_STATE;

   localparam int DEFAULT_MAX_OUTSTANDING = 32;
   localparam int TX_HEADER_W             = 61;

   typedef logic [TX_HEADER_W-1:0] t_TX_HEADER;

endpackage

// File: rtl/qa_drv_hc_read_arbiter_chk.sv
// Simulation-only invariants for the TX0 read arbiter.
module qa_drv_hc_read_arbiter_chk #(
   parameter int MAX_OUTSTANDING = 32,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input logic             clk,
   input logic             reset_n,
   input logic             status_grant,
   input logic             reader_grant,
   input logic             writer_grant,
   input logic [CNT_W-1:0] outstanding
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0({status_grant, reader_grant, writer_grant}))
      else $fatal(1, "read arbiter: more than one grant in a cycle");

   a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
      (outstanding <= MAX_CNT))
      else $fatal(1, "read arbiter: outstanding exceeds MAX_OUTSTANDING");

endmodule

// File: rtl/qa_drv_hc_read_credit.sv
// In-flight request counter with sticky underflow flag; shared by the TX0 read
// and TX1 write-response paths.
module qa_drv_hc_read_credit
   import qa_drv_hc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue,
   input  logic             rsp,
   output logic [CNT_W-1:0] count,
   output logic             room,
   output logic             err_underflow
);

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             room_r;
   logic             err_r;
   logic             underflow_s;

   // Next count; a response at zero is flagged and never wraps the counter.
   always_comb begin
      count_nxt_s = count_r;
      underflow_s = rsp && (count_r == ZERO_CNT);
      case ({issue, rsp})
         2'b10: count_nxt_s = count_r + ONE_CNT;
         2'b01: begin
            if (count_r == ZERO_CNT) begin
               count_nxt_s = ZERO_CNT;
            end else begin
               count_nxt_s = count_r - ONE_CNT;
            end
         end
         default: count_nxt_s = count_r;
      endcase
   end

   // Counter, registered room indication and sticky error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= ZERO_CNT;
         room_r  <= 1'b1;
         err_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         room_r  <= (count_nxt_s < MAX_CNT);
         err_r   <= err_r || underflow_s;
      end
   end

   assign count         = count_r;
   assign room          = room_r;
   assign err_underflow = err_r;

endmodule

// File: rtl/qa_drv_hc_read_arbiter.sv
// TX0 read arbiter: status/reader/writer arbitration with credit limit,
// almost-full throttling and an AFU-enable driven drain sequence.
module qa_drv_hc_read_arbiter
   import qa_drv_hc_pkg::*;
#(
   parameter int HDR_W            = TX_HEADER_W,
   parameter int MAX_OUTSTANDING  = DEFAULT_MAX_OUTSTANDING,
   parameter int STATUS_BURST_MAX = 4
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 afu_en,
   input  logic                                 status_req,
   input  logic [HDR_W-1:0]                     status_hdr,
   input  logic                                 reader_req,
   input  logic [HDR_W-1:0]                     reader_hdr,
   input  logic                                 writer_req,
   input  logic [HDR_W-1:0]                     writer_hdr,
   output logic                                 status_grant,
   output logic                                 reader_grant,
   output logic                                 writer_grant,
   output logic                                 can_issue,
   output logic                                 tx0_rdvalid,
   output logic [HDR_W-1:0]                     tx0_header,
   input  logic                                 tx0_almostfull,
   input  logic                                 rx0_rdrsp,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 quiesced,
   output logic                                 err_underflow
);

   localparam int                 CNT_W     = $clog2(MAX_OUTSTANDING + 1);
   localparam int                 BURST_W   = $clog2(STATUS_BURST_MAX + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(STATUS_BURST_MAX);
   localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
   localparam logic [CNT_W-1:0]   ZERO_CNT  = CNT_W'(0);

   t_RD_ARB_STATE      state_r;
   logic [BURST_W-1:0] burst_cnt_r;
   logic               almostfull_r;
   logic               rdvalid_r;
   logic [HDR_W-1:0]   header_r;
   logic               quiesced_r;

   logic               room_s;
   logic [CNT_W-1:0]   count_s;
   logic               can_issue_s;
   logic               other_pending_s;
   logic               status_blocked_s;
   logic               status_grant_s;
   logic               reader_grant_s;
   logic               writer_grant_s;
   logic               issue_s;
   logic [HDR_W-1:0]   grant_hdr_s;

   // Grant selection; the credit check sees the count before this cycle's response.
   always_comb begin
      can_issue_s      = afu_en && !almostfull_r && room_s && (state_r != DRAIN);
      other_pending_s  = reader_req || writer_req;
      status_blocked_s = (burst_cnt_r == BURST_MAX) && other_pending_s;
      status_grant_s   = can_issue_s && status_req && !status_blocked_s;
      reader_grant_s   = can_issue_s && !status_grant_s && reader_req &&
                         ((state_r == FAVOR_READER) || !writer_req);
      writer_grant_s   = can_issue_s && !status_grant_s && !reader_grant_s && writer_req;
      issue_s          = status_grant_s || reader_grant_s || writer_grant_s;
      if (status_grant_s) begin
         grant_hdr_s = status_hdr;
      end else if (reader_grant_s) begin
         grant_hdr_s = reader_hdr;
      end else begin
         grant_hdr_s = writer_hdr;
      end
   end

   // Arbitration FSM with its registered TX0 outputs and drain status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= FAVOR_READER;
         burst_cnt_r  <= '0;
         almostfull_r <= 1'b0;
         rdvalid_r    <= 1'b0;
         header_r     <= '0;
         quiesced_r   <= 1'b0;
      end else begin
         almostfull_r <= tx0_almostfull;
         rdvalid_r    <= issue_s;
         if (issue_s) begin
            header_r <= grant_hdr_s;
         end else begin
            header_r <= header_r;
         end
         quiesced_r <= (state_r == DRAIN) && (count_s == ZERO_CNT) && !rdvalid_r;

         if (reader_grant_s || writer_grant_s || !other_pending_s) begin
            burst_cnt_r <= '0;
         end else if (status_grant_s && (burst_cnt_r != BURST_MAX)) begin
            burst_cnt_r <= burst_cnt_r + BURST_ONE;
         end else begin
            burst_cnt_r <= burst_cnt_r;
         end

         if (!afu_en) begin
            state_r <= DRAIN;
         end else begin
            case (state_r)
               FAVOR_READER: state_r <= reader_grant_s ? FAVOR_WRITER : FAVOR_READER;
               FAVOR_WRITER: state_r <= writer_grant_s ? FAVOR_READER : FAVOR_WRITER;
               DRAIN:        state_r <= quiesced_r ? FAVOR_READER : DRAIN;
               default:      state_r <= FAVOR_READER;
            endcase
         end
      end
   end

   qa_drv_hc_read_credit #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_credit (
      .clk           (clk),
      .reset_n       (reset_n),
      .issue         (issue_s),
      .rsp           (rx0_rdrsp),
      .count         (count_s),
      .room          (room_s),
      .err_underflow (err_underflow)
   );

   qa_drv_hc_read_arbiter_chk #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_chk (
      .clk          (clk),
      .reset_n      (reset_n),
      .status_grant (status_grant_s),
      .reader_grant (reader_grant_s),
      .writer_grant (writer_grant_s),
      .outstanding  (count_s)
   );

   assign status_grant = status_grant_s;
   assign reader_grant = reader_grant_s;
   assign writer_grant = writer_grant_s;
   assign can_issue    = can_issue_s;
   assign tx0_rdvalid  = rdvalid_r;
   assign tx0_header   = header_r;
   assign outstanding  = count_s;
   assign quiesced     = quiesced_r;

endmodule

// File: tb/tb_qa_drv_hc_read_arbiter.sv
// Directed bench for the TX0 read arbiter; inputs change 1 time unit after
// the rising edge, combinational grants are sampled on the falling edge.
module tb_qa_drv_hc_read_arbiter;

   localparam int HDR_W = 61;
   localparam int CNT_W = 6;

   localparam logic [HDR_W-1:0] S_HDR = 61'h0555_0000_0000_0001;
   localparam logic [HDR_W-1:0] R_HDR = 61'h0123_4567_89AB_CDEF;
   localparam logic [HDR_W-1:0] W_HDR = 61'h1FED_CBA9_8765_4321;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             afu_en;
   logic             status_req, reader_req, writer_req;
   logic [HDR_W-1:0] status_hdr, reader_hdr, writer_hdr;
   logic             status_grant, reader_grant, writer_grant, can_issue;
   logic             tx0_rdvalid;
   logic [HDR_W-1:0] tx0_header;
   logic             tx0_almostfull, rx0_rdrsp;
   logic [CNT_W-1:0] outstanding;
   logic             quiesced, err_underflow;

   int n_pass  = 0;
   int n_total = 0;
   int grants  = 0;

   logic [2:0]       exp_pat [10];
   logic [HDR_W-1:0] exp_hdr;

   always #5 clk = ~clk;

   qa_drv_hc_read_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .afu_en         (afu_en),
      .status_req     (status_req),
      .status_hdr     (status_hdr),
      .reader_req     (reader_req),
      .reader_hdr     (reader_hdr),
      .writer_req     (writer_req),
      .writer_hdr     (writer_hdr),
      .status_grant   (status_grant),
      .reader_grant   (reader_grant),
      .writer_grant   (writer_grant),
      .can_issue      (can_issue),
      .tx0_rdvalid    (tx0_rdvalid),
      .tx0_header     (tx0_header),
      .tx0_almostfull (tx0_almostfull),
      .rx0_rdrsp      (rx0_rdrsp),
      .outstanding    (outstanding),
      .quiesced       (quiesced),
      .err_underflow  (err_underflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; afu_en = 1'b1;
      status_req = 1'b0; reader_req = 1'b0; writer_req = 1'b0;
      status_hdr = S_HDR; reader_hdr = R_HDR; writer_hdr = W_HDR;
      tx0_almostfull = 1'b0; rx0_rdrsp = 1'b0;
      exp_pat = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010,
                  3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
      step(); step();
      check("rst_valid", 64'(tx0_rdvalid), 64'd0);
      check("rst_hdr", 64'(tx0_header), 64'd0);
      check("rst_out", 64'(outstanding), 64'd0);
      check("rst_quiesced", 64'(quiesced), 64'd0);
      check("rst_err", 64'(err_underflow), 64'd0);
      reset_n = 1'b1;

      // Reader/writer alternate; one response per cycle after the first issue.
      for (int i = 0; i < 8; i++) begin
         reader_req = 1'b1; writer_req = 1'b1; rx0_rdrsp = (i != 0);
         @(negedge clk);
         check("alt_rgnt", 64'(reader_grant), 64'((i % 2) == 0));
         check("alt_wgnt", 64'(writer_grant), 64'((i % 2) == 1));
         step();
         check("alt_valid", 64'(tx0_rdvalid), 64'd1);
         check("alt_hdr", 64'(tx0_header), 64'(((i % 2) == 0) ? R_HDR : W_HDR));
         check("alt_out", 64'(outstanding), 64'd1);
      end
      reader_req = 1'b0; writer_req = 1'b0; rx0_rdrsp = 1'b1;
      step();
      rx0_rdrsp = 1'b0;
      check("alt_drain_out", 64'(outstanding), 64'd0);
      check("alt_drain_valid", 64'(tx0_rdvalid), 64'd0);

      // Status burst limit with all three requesting.
      for (int i = 0; i < 10; i++) begin
         status_req = 1'b1; reader_req = 1'b1; writer_req = 1'b1;
         @(negedge clk);
         check("burst_gnts", 64'({status_grant, reader_grant, writer_grant}), 64'(exp_pat[i]));
         step();
         exp_hdr = exp_pat[i][2] ? S_HDR : (exp_pat[i][1] ? R_HDR : W_HDR);
         check("burst_hdr", 64'(tx0_header), 64'(exp_hdr));
      end
      status_req = 1'b0; reader_req = 1'b0; writer_req = 1'b0;
      check("burst_out", 64'(outstanding), 64'd10);

      rx0_rdrsp = 1'b1;
      repeat (10) step();
      rx0_rdrsp = 1'b0;
      check("credit_start", 64'(outstanding), 64'd0);

      // Credit exhaustion: exactly 32 reads, then one per freed slot.
      reader_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (reader_grant) grants++;
         step();
      end
      check("credit_grants", 64'(grants), 64'd32);
      check("credit_out_full", 64'(outstanding), 64'd32);
      check("credit_can_issue", 64'(can_issue), 64'd0);
      rx0_rdrsp = 1'b1;
      @(negedge clk);
      check("credit_same_cyc", 64'(reader_grant), 64'd0);
      step();
      rx0_rdrsp = 1'b0;
      check("credit_out_31", 64'(outstanding), 64'd31);
      @(negedge clk);
      check("credit_refill", 64'(reader_grant), 64'd1);
      step();
      check("credit_out_32", 64'(outstanding), 64'd32);
      @(negedge clk);
      check("credit_full_again", 64'(reader_grant), 64'd0);
      step();
      reader_req = 1'b0; rx0_rdrsp = 1'b1;
      repeat (32) step();
      rx0_rdrsp = 1'b0;
      check("credit_drained", 64'(outstanding), 64'd0);

      // Almost-full: grant at N, none through one cycle after deassert.
      reader_req = 1'b1; tx0_almostfull = 1'b1;
      @(negedge clk);
      check("af_cycle_n", 64'(reader_grant), 64'd1);
      step();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("af_blocked", 64'(reader_grant), 64'd0);
         step();
      end
      tx0_almostfull = 1'b0;
      @(negedge clk);
      check("af_slip", 64'(reader_grant), 64'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("af_resume", 64'(reader_grant), 64'd1);
         step();
      end
      reader_req = 1'b0;
      check("af_out", 64'(outstanding), 64'd5);

      // Drain with 5 reads in flight, then re-enable.
      afu_en = 1'b0; reader_req = 1'b1;
      @(negedge clk);
      check("drain_no_grant", 64'(reader_grant), 64'd0);
      check("drain_can_issue", 64'(can_issue), 64'd0);
      step();
      rx0_rdrsp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("drain_rsp_no_grant", 64'(reader_grant), 64'd0);
         step();
      end
      rx0_rdrsp = 1'b0;
      check("drain_out0", 64'(outstanding), 64'd0);
      check("drain_not_yet", 64'(quiesced), 64'd0);
      step();
      check("drain_quiesced", 64'(quiesced), 64'd1);
      afu_en = 1'b1;
      @(negedge clk);
      check("reen_still_drain", 64'(reader_grant), 64'd0);
      step();
      writer_req = 1'b1;
      @(negedge clk);
      check("reen_reader_fav", 64'(reader_grant), 64'd1);
      check("reen_writer", 64'(writer_grant), 64'd0);
      step();
      reader_req = 1'b0; writer_req = 1'b0;
      check("reen_quiesced", 64'(quiesced), 64'd0);
      check("reen_out", 64'(outstanding), 64'd1);

      // Underflow, then asynchronous reset mid-cycle.
      rx0_rdrsp = 1'b1;
      step();
      check("uf_out0", 64'(outstanding), 64'd0);
      check("uf_err_clear", 64'(err_underflow), 64'd0);
      step();
      rx0_rdrsp = 1'b0;
      check("uf_err_set", 64'(err_underflow), 64'd1);
      check("uf_out_held", 64'(outstanding), 64'd0);
      reader_req = 1'b1;
      step();
      reader_req = 1'b0;
      check("pre_rst_valid", 64'(tx0_rdvalid), 64'd1);
      check("pre_rst_out", 64'(outstanding), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(tx0_rdvalid), 64'd0);
      check("arst_hdr", 64'(tx0_header), 64'd0);
      check("arst_out", 64'(outstanding), 64'd0);
      check("arst_err", 64'(err_underflow), 64'd0);
      check("arst_quiesced", 64'(quiesced), 64'd0);
      step();
      reset_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
